// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1:2 stream demultiplexer.
package demux_pkg;

    // Select encoding matches the 2:1 mux, so mux(demux(x)) == x for the same sel.
    localparam int unsigned SEL_A = 1;
    localparam int unsigned SEL_B = 0;

    // Only codes 0 and 1 route somewhere; anything else is dropped.
    function automatic logic sel_legal(input logic [31:0] sel);
        return (sel < 32'd2);
    endfunction

    // Saturation value of a drop counter that is w bits wide.
    function automatic int unsigned drop_cnt_max(input int unsigned w);
        if (w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/demux_stream_out_slot.sv
// One-beat output buffer behind a valid/ready handshake.
module demux_out_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             free
);

    // Slot can take a beat when empty or when its beat leaves this cycle.
    always_comb begin
        free = !valid || ready;
    end

    // Load has priority; otherwise the held beat clears once the sink takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream.sv
// 1:2 registered stream demultiplexer with illegal-select drop counting.
module demux_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEL_WIDTH = 1,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic [SEL_WIDTH-1:0] din_sel,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [WIDTH-1:0]     a,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b,
    output logic                 b_valid,
    input  logic                 b_ready,
    output logic                 drop,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(drop_cnt_max(CNT_WIDTH));

    logic legal;
    logic to_a;
    logic to_b;
    logic a_free;
    logic b_free;
    logic accept;
    logic load_a;
    logic load_b;

    // Decode select; a stalled target blocks din even if the other port is free.
    always_comb begin
        legal     = sel_legal(32'(din_sel));
        to_a      = (din_sel == SEL_WIDTH'(SEL_A));
        to_b      = (din_sel == SEL_WIDTH'(SEL_B));
        din_ready = 1'b0;
        if (!rst) begin
            if (legal) begin
                din_ready = to_a ? a_free : b_free;
            end else begin
                din_ready = 1'b1;
            end
        end
        accept = din_valid && din_ready;
        load_a = accept && legal && to_a;
        load_b = accept && legal && to_b;
    end

    demux_out_slot #(.WIDTH(WIDTH)) u_slot_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load_a),
        .din   (din),
        .dout  (a),
        .valid (a_valid),
        .ready (a_ready),
        .free  (a_free)
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load_b),
        .din   (din),
        .dout  (b),
        .valid (b_valid),
        .ready (b_ready),
        .free  (b_free)
    );

    // Pulse on each discarded beat and count it, holding at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop <= accept && !legal;
            if (accept && !legal && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
